// File: rtl/gen_scroll_layer_pkg.sv
// Shared widths, defaults and helpers for the scrolling background layer.
package gen_scroll_layer_pkg;

  localparam int unsigned ColorW     = 12;
  localparam int unsigned ScreenWDef = 640;
  localparam int unsigned CntW       = 10;
  localparam int unsigned PosW       = 11;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Add a step to an offset and fold it back once into 0..width-1
  function automatic logic [11:0] wrap_add(input logic [11:0] a, input logic [11:0] b,
                                           input logic [11:0] width);
    logic [11:0] s;
    s = a + b;
    if (s >= width) s = s - width;
    return s;
  endfunction

endpackage

// File: rtl/scroll_addr_gen.sv
// Band detection and ROM address generation: stage A (band/row/col) and stage B (address).
module scroll_addr_gen
  import gen_scroll_layer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 1187,
  parameter int unsigned IMG_HEIGHT = 14,
  parameter int unsigned YPOS       = 300,
  parameter int unsigned SCREEN_W   = ScreenWDef,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CntW-1:0]   h_cnt,
  input  logic [CntW-1:0]   v_cnt,
  input  logic [PosW-1:0]   disp_pos,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              band
);

  localparam int unsigned YTop = YPOS - IMG_HEIGHT;

  logic              in_band;
  logic [CntW-1:0]   row_d;
  logic [11:0]       col_d;
  logic              band_a_q;
  logic [CntW-1:0]   row_a_q;
  logic [11:0]       col_a_q;
  logic              band_b_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Stage A inputs: band window, row inside the band, wrapped image column
  always_comb begin
    in_band = (32'(v_cnt) >= YTop) && (32'(v_cnt) < YPOS) && (32'(h_cnt) < SCREEN_W);
    row_d   = v_cnt - CntW'(YTop);
    col_d   = wrap_add({2'b00, h_cnt}, {1'b0, disp_pos}, 12'(IMG_WIDTH));
  end

  // Stage A register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      band_a_q <= 1'b0;
      row_a_q  <= '0;
      col_a_q  <= '0;
    end else begin
      band_a_q <= in_band;
      row_a_q  <= row_d;
      col_a_q  <= col_d;
    end
  end

  // Linear ROM address; held outside the band
  always_comb begin
    addr_d = addr_q;
    if (band_a_q) addr_d = ADDR_W'(row_a_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(col_a_q);
  end

  // Stage B register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      band_b_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      band_b_q <= band_a_q;
      addr_q   <= addr_d;
    end
  end

  assign rom_addr = addr_q;
  assign band     = band_b_q;

endmodule

// File: rtl/gen_scroll_layer.sv
// One horizontally wrapping image band with frame-synchronous scrolling and optional key colour.
module gen_scroll_layer
  import gen_scroll_layer_pkg::*;
#(
  parameter int unsigned       IMG_WIDTH  = 1187,
  parameter int unsigned       IMG_HEIGHT = 14,
  parameter int unsigned       YPOS       = 300,
  parameter int unsigned       SCREEN_W   = ScreenWDef,
  parameter int unsigned       SPEED_W    = 4,
  parameter int unsigned       ADDR_W     = 17,
  parameter int unsigned       ROM_LAT    = 1,
  parameter logic [ColorW-1:0] BG_COLOR   = 12'hFFF,
  parameter bit                KEY_EN     = 1'b0,
  parameter logic [ColorW-1:0] KEY_COLOR  = 12'hFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_tick,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed,
  input  logic [CntW-1:0]    h_cnt,
  input  logic [CntW-1:0]    v_cnt,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [ColorW-1:0]  rom_data,
  output logic [3:0]         vgaRed,
  output logic [3:0]         vgaGreen,
  output logic [3:0]         vgaBlue,
  output logic               layer_hit,
  output logic [PosW-1:0]    scroll_pos
);

  if (IMG_WIDTH < SCREEN_W) begin : g_chk_width
    $error("IMG_WIDTH must be >= SCREEN_W");
  end
  if (IMG_WIDTH * IMG_HEIGHT > (1 << ADDR_W)) begin : g_chk_addr
    $error("IMG_WIDTH*IMG_HEIGHT does not fit in ADDR_W");
  end
  if (ROM_LAT < 1) begin : g_chk_lat
    $error("ROM_LAT must be at least 1");
  end

  logic [PosW-1:0]    scroll_q;
  logic [PosW-1:0]    scroll_d;
  logic [11:0]        scroll_sum;
  logic [PosW-1:0]    disp_q;
  logic               band_b;
  logic [ROM_LAT-1:0] band_dly_q;
  logic               opaque;
  rgb_t               rgb_q;
  logic               hit_q;

  // Next scroll offset: advance by speed on an enabled tick, wrapping once
  always_comb begin
    scroll_sum = wrap_add({1'b0, scroll_q}, 12'(speed), 12'(IMG_WIDTH));
    scroll_d   = scroll_q;
    if (game_tick && enable) scroll_d = scroll_sum[PosW-1:0];
  end

  // Live offset, plus the per-frame copy latched at (0,0) so a frame never tears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scroll_q <= '0;
      disp_q   <= '0;
    end else begin
      scroll_q <= scroll_d;
      if (h_cnt == '0 && v_cnt == '0) disp_q <= scroll_q;
    end
  end

  scroll_addr_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .YPOS       (YPOS),
    .SCREEN_W   (SCREEN_W),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .disp_pos (disp_q),
    .rom_addr (rom_addr),
    .band     (band_b)
  );

  // Band flag follows the ROM read latency so it lines up with rom_data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      band_dly_q <= '0;
    end else begin
      band_dly_q[0] <= band_b;
      for (int i = 1; i < int'(ROM_LAT); i++) band_dly_q[i] <= band_dly_q[i-1];
    end
  end

  assign opaque = band_dly_q[ROM_LAT-1] && !(KEY_EN && (rom_data == KEY_COLOR));

  // Final colour register: ROM pixel when opaque, background otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= rgb_t'(BG_COLOR);
      hit_q <= 1'b0;
    end else begin
      rgb_q <= opaque ? rgb_t'(rom_data) : rgb_t'(BG_COLOR);
      hit_q <= opaque;
    end
  end

  assign vgaRed     = rgb_q.r;
  assign vgaGreen   = rgb_q.g;
  assign vgaBlue    = rgb_q.b;
  assign layer_hit  = hit_q;
  assign scroll_pos = scroll_q;

endmodule

// File: tb/tb_gen_scroll_layer.sv
// Self-checking bench: random traffic against a reference model, a vector table, directed corners.
module tb_gen_scroll_layer;

  localparam int W  = 1187;
  localparam int Y0 = 286;
  localparam int Y1 = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        game_tick = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  speed = '0;
  logic [9:0]  h_cnt = 10'd700;
  logic [9:0]  v_cnt = 10'd400;
  logic [16:0] rom_addr, rom_addr2;
  logic [11:0] rom_data, rom_data2;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        hit1, hit2;
  logic [10:0] scroll_pos, scroll_pos2;
  bit          key_all = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gen_scroll_layer u_dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .enable(enable), .speed(speed),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .rom_addr(rom_addr), .rom_data(rom_data),
    .vgaRed(r1), .vgaGreen(g1), .vgaBlue(b1), .layer_hit(hit1), .scroll_pos(scroll_pos)
  );

  gen_scroll_layer #(.KEY_EN(1'b1), .KEY_COLOR(12'hFFF)) u_dut_key (
    .clk(clk), .rst(rst), .game_tick(game_tick), .enable(enable), .speed(speed),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .vgaRed(r2), .vgaGreen(g2), .vgaBlue(b2), .layer_hit(hit2), .scroll_pos(scroll_pos2)
  );

  // Image contents: never FFF unless key_all forces it; 4761 holds a known pixel
  function automatic logic [11:0] rom_fn(input int addr);
    if (key_all) return 12'hFFF;
    if (addr == 4761) return 12'h555;
    return 12'(addr * 7 + 1) & 12'hFFE;
  endfunction

  // One-cycle ROM
  always @(posedge clk) begin
    rom_data  <= rom_fn(int'(rom_addr));
    rom_data2 <= rom_fn(int'(rom_addr2));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    h_cnt = 10'd700;
    v_cnt = 10'd400;
  endtask

  task automatic tick(input int spd, input bit en);
    @(negedge clk);
    speed = 4'(spd); enable = en; game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
  endtask

  task automatic latch_frame();
    @(negedge clk);
    h_cnt = '0; v_cnt = '0;
    @(negedge clk);
    idle_inputs();
  endtask

  // Present one pixel for one cycle, capture address after 2 clks and colour after 4
  task automatic apply_px(input int hh, input int vv, output logic [16:0] a,
                          output logic [11:0] c1, output logic h1,
                          output logic [11:0] c2, output logic h2);
    @(negedge clk);
    h_cnt = 10'(hh); v_cnt = 10'(vv);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    a = rom_addr;
    @(negedge clk);
    @(negedge clk);
    c1 = {r1, g1, b1}; h1 = hit1;
    c2 = {r2, g2, b2}; h2 = hit2;
  endtask

  typedef struct {
    int hh;
    int vv;
    bit inb;
    int exp_addr;
  } vec_t;

  vec_t tab[9];

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int m_scroll, m_disp, m_last_addr;
    logic [31:0] q_rgb1[$], q_hit1[$], q_rgb2[$], q_hit2[$], q_addr[$];
    logic [16:0] a;
    logic [11:0] c1, c2;
    logic        h1, h2;

    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Random traffic against the reference model (state starts from reset)
    m_scroll = 0; m_disp = 0; m_last_addr = 0;
    repeat (3000) begin
      int hh, vv, ad;
      bit tk, en, inb;
      int sp;
      logic [11:0] px;
      @(negedge clk);
      if (q_rgb1.size() == 4) begin
        check("rnd_rgb",  32'({r1, g1, b1}), q_rgb1.pop_front());
        check("rnd_hit",  32'(hit1), q_hit1.pop_front());
        check("rnd_rgbk", 32'({r2, g2, b2}), q_rgb2.pop_front());
        check("rnd_hitk", 32'(hit2), q_hit2.pop_front());
      end
      if (q_addr.size() == 2) check("rnd_addr", 32'(rom_addr), q_addr.pop_front());
      check("rnd_scroll", 32'(scroll_pos), 32'(m_scroll));

      if ($urandom_range(0, 39) == 0) begin
        hh = 0; vv = 0;
      end else begin
        hh = $urandom_range(0, 700);
        vv = $urandom_range(283, 303);
      end
      tk = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 4) != 0);
      sp = $urandom_range(0, 15);
      h_cnt = 10'(hh); v_cnt = 10'(vv); game_tick = tk; enable = en; speed = 4'(sp);

      inb = (vv >= Y0) && (vv < Y1) && (hh < 640);
      ad  = (vv - Y0) * W + (hh + m_disp) % W;
      px  = inb ? rom_fn(ad) : 12'hFFF;
      if (inb) m_last_addr = ad;
      q_rgb1.push_back(32'(inb ? px : 12'hFFF));
      q_hit1.push_back(32'(inb));
      q_rgb2.push_back(32'((inb && px != 12'hFFF) ? px : 12'hFFF));
      q_hit2.push_back(32'(inb && px != 12'hFFF));
      q_addr.push_back(32'(m_last_addr));

      if (hh == 0 && vv == 0) m_disp = m_scroll;
      if (tk && en) m_scroll = (m_scroll + sp) % W;
    end
    @(negedge clk);
    game_tick = 1'b0;

    // Reset in the middle of a line takes effect without a clock edge
    repeat (5) begin
      @(negedge clk);
      h_cnt = 10'd100; v_cnt = 10'd290;
    end
    #2 rst = 1'b0;
    #1;
    check("rst_rgb", 32'({r1, g1, b1}), 32'h0FFF);
    check("rst_hit", 32'(hit1), 32'd0);
    check("rst_scroll", 32'(scroll_pos), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Scroll arithmetic and wrap
    repeat (400) tick(3, 1'b1);
    check("scroll_400x3", 32'(scroll_pos), 32'd13);
    repeat (78) tick(15, 1'b1);
    tick(2, 1'b1);
    check("scroll_1185", 32'(scroll_pos), 32'd1185);
    tick(3, 1'b1);
    check("scroll_wrap", 32'(scroll_pos), 32'd1);
    tick(5, 1'b0);
    check("scroll_disabled", 32'(scroll_pos), 32'd1);
    tick(0, 1'b1);
    check("scroll_speed0", 32'(scroll_pos), 32'd1);
    repeat (66) tick(15, 1'b1);
    tick(9, 1'b1);
    check("scroll_1000", 32'(scroll_pos), 32'd1000);
    latch_frame();

    // Vector table at disp_pos = 1000
    tab[0] = '{200, 290, 1'b1, 4761};
    tab[1] = '{187, 286, 1'b1, 0};
    tab[2] = '{186, 286, 1'b1, 1186};
    tab[3] = '{639, 299, 1'b1, 15883};
    tab[4] = '{0,   295, 1'b1, 11683};
    tab[5] = '{100, 285, 1'b0, 0};
    tab[6] = '{100, 300, 1'b0, 0};
    tab[7] = '{650, 290, 1'b0, 0};
    tab[8] = '{640, 299, 1'b0, 0};
    for (int i = 0; i < 9; i++) begin
      apply_px(tab[i].hh, tab[i].vv, a, c1, h1, c2, h2);
      if (tab[i].inb) check($sformatf("tab%0d_addr", i), 32'(a), 32'(tab[i].exp_addr));
      check($sformatf("tab%0d_rgb", i), 32'(c1),
            32'(tab[i].inb ? rom_fn(tab[i].exp_addr) : 12'hFFF));
      check($sformatf("tab%0d_hit", i), 32'(h1), 32'(tab[i].inb));
      check($sformatf("tab%0d_hitk", i), 32'(h2), 32'(tab[i].inb));
    end

    // Mid-frame tick does not move the image until the next frame start
    tick(5, 1'b1);
    apply_px(200, 290, a, c1, h1, c2, h2);
    check("midframe_addr", 32'(a), 32'd4761);
    check("midframe_rgb", 32'(c1), 32'h555);
    // Tick coinciding with (0,0): frame gets the pre-tick offset
    @(negedge clk);
    h_cnt = '0; v_cnt = '0; speed = 4'd5; enable = 1'b1; game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    idle_inputs();
    check("same_cycle_scroll", 32'(scroll_pos), 32'd1010);
    apply_px(200, 290, a, c1, h1, c2, h2);
    check("same_cycle_addr", 32'(a), 32'd4766);
    latch_frame();
    apply_px(200, 290, a, c1, h1, c2, h2);
    check("next_frame_addr", 32'(a), 32'd4771);

    // Key colour: plain layer stays opaque, keyed layer becomes transparent
    key_all = 1'b1;
    apply_px(200, 290, a, c1, h1, c2, h2);
    check("key_plain_hit", 32'(h1), 32'd1);
    check("key_plain_rgb", 32'(c1), 32'h0FFF);
    check("key_keyed_hit", 32'(h2), 32'd0);
    check("key_keyed_rgb", 32'(c2), 32'h0FFF);
    key_all = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
